counter_run_scheduler: RTL

- Time-shares one `counter` instance (WIDTH-bit up-counter that increments every clk unless cleared) between NUM_REQ requesters.
- Each requester asks for a run of N counts.
- The scheduler arbitrates round-robin, clears the counter, watches `cnt_count` until the run length is reached, then acknowledges the winner.
- Sits between the requesting blocks and the counter's sync clear/count/done ports.

---
 rtl/counter_run_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/counter_run_scheduler.sv
// Round-robin scheduler that time-shares one up-counter among NUM_REQ requesters.
// Each grant clears the counter, waits for the requested count, then acks the owner.
module counter_run_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  input  logic [WIDTH-1:0]         cnt_count,
  input  logic                     cnt_done,
  output logic                     cnt_clear,
  output logic [NUM_REQ-1:0]       grant,
  output logic [GRANT_W-1:0]       grant_idx,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     err,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t               r_state,     w_state_nxt;
  logic                 r_cnt_clear, w_cnt_clear_nxt;
  logic [NUM_REQ-1:0]   r_grant,     w_grant_nxt;
  logic [GRANT_W-1:0]   r_grant_idx, w_grant_idx_nxt;
  logic [NUM_REQ-1:0]   r_ack,       w_ack_nxt;
  logic                 r_err,       w_err_nxt;
  logic                 r_busy,      w_busy_nxt;
  logic [GRANT_W-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
  logic [WIDTH-1:0]     r_target,    w_target_nxt;

  logic                 w_pick_vld;
  logic [GRANT_W-1:0]   w_pick_idx;
  logic [GRANT_W:0]     w_cand;

  function automatic logic [GRANT_W-1:0] next_ptr(input logic [GRANT_W-1:0] p);
    if (p == GRANT_W'(NUM_REQ - 1)) return '0;
    return p + GRANT_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GRANT_W-1:0] p);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Search starts at rr_ptr; walking offsets downwards lets the smallest offset win.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (GRANT_W+1)'(k);
      if (w_cand >= (GRANT_W+1)'(NUM_REQ)) w_cand = w_cand - (GRANT_W+1)'(NUM_REQ);
      if (req[w_cand[GRANT_W-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand[GRANT_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_clear_nxt = 1'b0;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_ack_nxt       = '0;
    w_err_nxt       = 1'b0;
    w_busy_nxt      = r_busy;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_target_nxt    = r_target;
    case (r_state)
      IDLE: begin
        w_grant_nxt     = '0;
        w_grant_idx_nxt = '0;
        w_busy_nxt      = 1'b0;
        if (w_pick_vld) begin
          w_state_nxt     = CLEAR;
          w_cnt_clear_nxt = 1'b1;
          w_grant_nxt     = onehot(w_pick_idx);
          w_grant_idx_nxt = w_pick_idx;
          w_busy_nxt      = 1'b1;
          w_target_nxt    = req_len[int'(w_pick_idx)*WIDTH +: WIDTH];
        end
      end
      CLEAR: begin
        if (r_target == '0) begin
          w_state_nxt = DONE;
          w_ack_nxt   = onehot(r_grant_idx);
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // Owner withdrawal beats completion, which beats counter termination.
        if (!req[r_grant_idx]) begin
          w_state_nxt     = IDLE;
          w_grant_nxt     = '0;
          w_grant_idx_nxt = '0;
          w_busy_nxt      = 1'b0;
          w_rr_ptr_nxt    = next_ptr(r_grant_idx);
        end else if (cnt_count == r_target) begin
          w_state_nxt = DONE;
          w_ack_nxt   = onehot(r_grant_idx);
        end else if (cnt_done) begin
          w_state_nxt = DONE;
          w_ack_nxt   = onehot(r_grant_idx);
          w_err_nxt   = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt     = IDLE;
        w_grant_nxt     = '0;
        w_grant_idx_nxt = '0;
        w_busy_nxt      = 1'b0;
        w_rr_ptr_nxt    = next_ptr(r_grant_idx);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt_clear <= 1'b0;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_rr_ptr    <= '0;
      r_target    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt_clear <= w_cnt_clear_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_ack       <= w_ack_nxt;
      r_err       <= w_err_nxt;
      r_busy      <= w_busy_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_target    <= w_target_nxt;
    end
  end

  assign cnt_clear = r_cnt_clear;
  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign ack       = r_ack;
  assign err       = r_err;
  assign busy      = r_busy;

endmodule
